// File: rtl/fifo_arb_pkg.sv
// Shared types for fifo_wr_arbiter: FSM state encoding and owner-index width helper.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Owner index width; a single requester still needs a 1-bit index.
  function automatic int owner_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int OWNER_W = owner_w(2);

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin scan: first set request starting one past the last owner.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int OWN_W = owner_w(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [OWN_W-1:0] i_last_owner,
  output logic [OWN_W-1:0] o_winner,
  output logic             o_any_valid
);

  int w_idx;

  // Scan from the farthest offset down so the nearest set request is written last.
  always_comb begin
    o_winner    = '0;
    o_any_valid = 1'b0;
    w_idx       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(i_last_owner) + k) % NREQ;
      if (i_req[w_idx[OWN_W-1:0]]) begin
        o_winner    = w_idx[OWN_W-1:0];
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NREQ producers.
// Optional per-requester accepted-word counters enabled by macro FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int NREQ      = 2,
  parameter  int MAX_BURST = 4,
  localparam int OWN_W     = owner_w(NREQ)
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic                  fifo_wr_rq,
  output logic [WIDTH-1:0]      fifo_wdata,
  input  logic                  fifo_full,
  output logic [OWN_W-1:0]      owner,
  output logic                  busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*8-1:0]     word_cnt
`endif
);

  localparam int                 BURST_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [OWN_W-1:0]   r_owner;
  logic [OWN_W-1:0]   w_owner_next;
  logic [OWN_W-1:0]   r_last_owner;
  logic [OWN_W-1:0]   w_last_owner_next;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [BURST_W-1:0] w_burst_next;
  logic [OWN_W-1:0]   w_winner;
  logic               w_any_valid;
  logic               w_owner_req;
  logic               w_wr_rq;

  rr_picker #(
    .NREQ  (NREQ),
    .OWN_W (OWN_W)
  ) u_picker (
    .i_req        (req),
    .i_last_owner (r_last_owner),
    .o_winner     (w_winner),
    .o_any_valid  (w_any_valid)
  );

  assign w_owner_req = req[r_owner];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= OWN_W'(NREQ - 1);
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_owner <= w_last_owner_next;
      r_burst_cnt  <= w_burst_next;
    end
  end

  // A full stall keeps the grant; only an owner drop or the last burst word releases it.
  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_last_owner_next = r_last_owner;
    w_burst_next      = r_burst_cnt;
    w_wr_rq           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_next = ST_GRANT;
          w_owner_next = w_winner;
        end
      end
      ST_GRANT: begin
        w_wr_rq = w_owner_req & ~fifo_full;
        if (!w_owner_req || (w_wr_rq && (r_burst_cnt == BURST_LAST))) begin
          w_state_next      = ST_IDLE;
          w_last_owner_next = r_owner;
          w_burst_next      = '0;
        end else if (w_wr_rq) begin
          w_burst_next = r_burst_cnt + BURST_W'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign fifo_wr_rq = w_wr_rq;
  assign fifo_wdata = w_wr_rq ? req_data[int'(r_owner)*WIDTH +: WIDTH] : '0;
  assign owner      = r_owner;
  assign busy       = (r_state == ST_GRANT);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
    assign ack[gi] = w_wr_rq & (r_owner == OWN_W'(gi));
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
    logic [7:0] r_cnt;
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (ack[gi]) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
    assign word_cnt[gi*8 +: 8] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with two producers, MAX_BURST=4, WIDTH=4.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 4;
  localparam int NREQ      = 2;
  localparam int MAX_BURST = 4;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic [1:0] req;
  logic [7:0] req_data;
  logic [1:0] ack;
  logic       fifo_wr_rq;
  logic [3:0] fifo_wdata;
  logic       fifo_full;
  logic [0:0] owner;
  logic       busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] word_cnt;
`endif

  always #5 clk_in = ~clk_in;

  fifo_wr_arbiter #(
    .WIDTH     (WIDTH),
    .NREQ      (NREQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_wr_rq (fifo_wr_rq),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .owner      (owner),
    .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  typedef struct packed {
    logic [0:0] idx;
    logic [3:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] p_q0[$];
  logic [3:0] p_q1[$];
  logic [1:0] p_en;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         model_cnt0 = 0;
  int         model_cnt1 = 0;
  logic [1:0] obs_ack;
  logic       obs_busy;
  logic       obs_wr_rq;
  logic [0:0] obs_owner;

  task automatic drive_inputs();
    req[0]        = p_en[0] && (p_q0.size() > 0);
    req[1]        = p_en[1] && (p_q1.size() > 0);
    req_data[3:0] = (p_q0.size() > 0) ? p_q0[0] : 4'h0;
    req_data[7:4] = (p_q1.size() > 0) ? p_q1[0] : 4'h0;
  endtask

  // One clock: sample outputs at negedge, retire accepted words at posedge, re-drive.
  task automatic step();
    @(negedge clk_in);
    obs_ack   = ack;
    obs_busy  = busy;
    obs_wr_rq = fifo_wr_rq;
    obs_owner = owner;
    @(posedge clk_in);
    #1;
    if (rst_n) begin
      if (obs_ack[0] && p_q0.size() > 0) void'(p_q0.pop_front());
      if (obs_ack[1] && p_q1.size() > 0) void'(p_q1.pop_front());
    end
    drive_inputs();
  endtask

  // Scoreboard: every written word must be the next expected (owner, data) pair.
  always @(negedge clk_in) begin
    exp_t       e;
    logic [1:0] exp_ack;
    if (!rst_n) begin
      model_cnt0 = 0;
      model_cnt1 = 0;
    end else if (ack != 2'b00 || fifo_wr_rq) begin
      if (ack[0]) model_cnt0++;
      if (ack[1]) model_cnt1++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got ack=%b wr_rq=%b wdata=%h, expected no write", ack, fifo_wr_rq, fifo_wdata);
      end else begin
        e = sb.pop_front();
        exp_ack = (e.idx == 1'b1) ? 2'b10 : 2'b01;
        if ({ack, fifo_wr_rq, fifo_wdata, owner} !== {exp_ack, 1'b1, e.data, e.idx})
          $display("FAIL sb_word: got ack=%b wr_rq=%b wdata=%h owner=%0d, expected ack=%b wr_rq=1 wdata=%h owner=%0d",
                   ack, fifo_wr_rq, fifo_wdata, owner, exp_ack, e.data, e.idx);
        else
          n_pass++;
      end
    end
  end

  task automatic apply_reset();
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    p_q0.delete();
    p_q1.delete();
    p_en = 2'b11;
    drive_inputs();
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic push_word(input logic src, input logic [3:0] d);
    exp_t e;
    e.idx  = src;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    p_en      = 2'b11;
    p_q0.push_back(4'h3);
    p_q1.push_back(4'hC);
    drive_inputs();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    n_checks++;
    if ({ack, fifo_wr_rq, busy, owner, fifo_wdata} !== {2'b00, 1'b0, 1'b0, 1'b0, 4'h0})
      $display("FAIL reset_outputs: got ack=%b wr_rq=%b busy=%b owner=%0d wdata=%h, expected 00 0 0 0 0",
               ack, fifo_wr_rq, busy, owner, fifo_wdata);
    else
      n_pass++;
`ifdef FIFO_ARB_STATS_EN
    n_checks++;
    if (word_cnt !== 16'h0) $display("FAIL reset_word_cnt: got %h, expected 0000", word_cnt);
    else n_pass++;
`endif
    $display("reset: ack=%b wr_rq=%b busy=%b owner=%0d", ack, fifo_wr_rq, busy, owner);
  endtask

  task automatic test_single();
    logic [9:0] pat;
    apply_reset();
    pat = 10'b1111011110;
    p_en = 2'b01;
    for (int k = 0; k < 8; k++) begin
      p_q0.push_back(4'hA);
      push_word(1'b0, 4'hA);
    end
    drive_inputs();
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if ({obs_ack, obs_busy} !== {1'b0, pat[c], pat[c]})
        $display("FAIL single_cycle%0d: got ack=%b busy=%b, expected ack=0%b busy=%b", c, obs_ack, obs_busy, pat[c], pat[c]);
      else
        n_pass++;
      $display("single: cycle %0d ack=%b busy=%b owner=%0d", c, obs_ack, obs_busy, obs_owner);
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL single_drain: got %0d words pending, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [3:0] d0[8];
    logic [3:0] d1[8];
    int         cyc;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      d0[k] = 4'($urandom);
      d1[k] = 4'($urandom);
      p_q0.push_back(d0[k]);
      p_q1.push_back(d1[k]);
    end
    for (int g = 0; g < 4; g++)
      for (int w = 0; w < 4; w++)
        push_word(g[0], g[0] ? d1[(g/2)*4 + w] : d0[(g/2)*4 + w]);
    drive_inputs();
    cyc = 0;
    while ((p_q0.size() > 0 || p_q1.size() > 0) && cyc < 60) begin
      step();
      n_checks++;
      if ((obs_ack != 2'b00) !== ((cyc % 5) != 0))
        $display("FAIL contention_cycle%0d: got ack=%b, expected write=%0d", cyc, obs_ack, (cyc % 5) != 0);
      else
        n_pass++;
      $display("contention: cycle %0d ack=%b owner=%0d", cyc, obs_ack, obs_owner);
      cyc++;
    end
    n_checks++;
    if (cyc != 20) $display("FAIL contention_cycles: got %0d, expected 20", cyc);
    else n_pass++;
    n_checks++;
    if (sb.size() != 0) $display("FAIL contention_drain: got %0d words pending, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int acks;
    int cyc;
    logic [3:0] d;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      d = 4'($urandom);
      p_q0.push_back(d);
      push_word(1'b0, d);
    end
    drive_inputs();
    acks = 0;
    cyc  = 0;
    while (acks < 2 && cyc < 10) begin
      step();
      if (obs_ack[0]) acks++;
      cyc++;
    end
    n_checks++;
    if (acks != 2) $display("FAIL bp_first_words: got %0d acks, expected 2", acks);
    else n_pass++;
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if ({obs_ack, obs_wr_rq, obs_busy} !== 4'b0001)
        $display("FAIL bp_stall%0d: got ack=%b wr_rq=%b busy=%b, expected 00 0 1", c, obs_ack, obs_wr_rq, obs_busy);
      else
        n_pass++;
      $display("backpressure: stall %0d ack=%b busy=%b", c, obs_ack, obs_busy);
    end
    fifo_full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if ({obs_ack, obs_busy} !== 3'b011)
        $display("FAIL bp_resume%0d: got ack=%b busy=%b, expected 01 1", c, obs_ack, obs_busy);
      else
        n_pass++;
    end
    step();
    n_checks++;
    if ({obs_ack, obs_busy} !== 3'b000)
      $display("FAIL bp_end: got ack=%b busy=%b, expected 00 0", obs_ack, obs_busy);
    else
      n_pass++;
  endtask

  task automatic test_owner_drop();
    int cyc;
    logic [3:0] d;
    apply_reset();
    d = 4'($urandom);
    p_q0.push_back(d);
    p_q0.push_back(~d);
    push_word(1'b0, d);
    for (int k = 0; k < 4; k++) begin
      d = 4'($urandom);
      p_q1.push_back(d);
      push_word(1'b1, d);
    end
    drive_inputs();
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!obs_ack[0] && cyc < 10);
    n_checks++;
    if (!obs_ack[0]) $display("FAIL drop_first: got no ack from req0 in %0d cycles, expected one", cyc);
    else n_pass++;
    p_en[0] = 1'b0;
    drive_inputs();
    step();
    n_checks++;
    if ({obs_ack, obs_wr_rq} !== 3'b000)
      $display("FAIL drop_release: got ack=%b wr_rq=%b, expected 00 0", obs_ack, obs_wr_rq);
    else
      n_pass++;
    step();
    n_checks++;
    if ({obs_ack, obs_busy} !== 3'b000)
      $display("FAIL drop_idle: got ack=%b busy=%b, expected 00 0", obs_ack, obs_busy);
    else
      n_pass++;
    step();
    n_checks++;
    if ({obs_ack, obs_owner, obs_busy} !== 4'b1011)
      $display("FAIL drop_regrant: got ack=%b owner=%0d busy=%b, expected 10 1 1", obs_ack, obs_owner, obs_busy);
    else
      n_pass++;
    $display("owner_drop: regrant ack=%b owner=%0d", obs_ack, obs_owner);
    cyc = 0;
    while (p_q1.size() > 0 && cyc < 10) begin
      step();
      cyc++;
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL drop_drain: got %0d words pending, expected 0", sb.size());
    else n_pass++;
    p_en = 2'b11;
  endtask

  task automatic test_async_reset();
    int acks;
    int cyc;
    logic [3:0] d;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      d = 4'($urandom);
      p_q0.push_back(d);
      if (k < 2) push_word(1'b0, d);
      d = 4'($urandom);
      p_q1.push_back(d);
    end
    drive_inputs();
    acks = 0;
    cyc  = 0;
    while (acks < 2 && cyc < 10) begin
      step();
      if (obs_ack[0]) acks++;
      cyc++;
    end
    #1;
    n_checks++;
    if (fifo_wr_rq !== 1'b1) $display("FAIL arst_pre: got wr_rq=%b, expected 1", fifo_wr_rq);
    else n_pass++;
`ifdef FIFO_ARB_STATS_EN
    n_checks++;
    if (word_cnt !== {8'(model_cnt1), 8'(model_cnt0)})
      $display("FAIL arst_cnt_pre: got %h, expected %02h%02h", word_cnt, 8'(model_cnt1), 8'(model_cnt0));
    else
      n_pass++;
`endif
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fifo_wr_rq, ack, busy, owner} !== 5'b00000)
      $display("FAIL arst_drop: got wr_rq=%b ack=%b busy=%b owner=%0d, expected 0 00 0 0", fifo_wr_rq, ack, busy, owner);
    else
      n_pass++;
    $display("async_reset: during reset wr_rq=%b ack=%b", fifo_wr_rq, ack);
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    foreach (p_q0[k]) push_word(1'b0, p_q0[k]);
    foreach (p_q1[k]) push_word(1'b1, p_q1[k]);
    cyc = 0;
    while ((p_q0.size() > 0 || p_q1.size() > 0) && cyc < 40) begin
      step();
      cyc++;
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL arst_drain: got %0d words pending, expected 0", sb.size());
    else n_pass++;
`ifdef FIFO_ARB_STATS_EN
    step();
    n_checks++;
    if (word_cnt !== {8'(model_cnt1), 8'(model_cnt0)})
      $display("FAIL arst_cnt_post: got %h, expected %02h%02h", word_cnt, 8'(model_cnt1), 8'(model_cnt0));
    else
      n_pass++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req       = 2'b00;
    req_data  = 8'h00;
    fifo_full = 1'b0;
    p_en      = 2'b11;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_owner_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
